// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle responder for the MEM-stage data-memory port.
// Each accepted load/store holds the pipeline with Mem_Stall for LATENCY cycles,
// then spends one RESP cycle with Resp_Valid high while the pipeline advances.
// The array write and the Read_data update both land on the edge entering RESP.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_data,
    output logic        Resp_Valid,
    output logic        Mem_Stall,
    output logic        Addr_Err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_count;
    logic                r_is_store;
    logic                r_bad_addr;
    logic [ADDR_W-1:0]   r_word;
    logic [31:0]         r_wdata;
    logic [31:0]         r_read_data;
    logic                r_resp_valid;
    logic                r_addr_err;
    logic [31:0]         r_mem [0:(2**ADDR_W)-1];

    logic                w_req;
    logic                w_accept;
    logic                w_bad_addr;
    logic                w_enter_resp;
    logic                w_in_idle;
    logic                w_cur_store;
    logic                w_cur_bad;
    logic [ADDR_W-1:0]   w_cur_word;
    logic [31:0]         w_cur_wdata;

    assign w_req      = MemRead | MemWrite;
    // Acceptance is also gated by RESET so Mem_Stall drops the instant reset rises,
    // even while a request is still presented.
    assign w_accept   = (r_state == ST_IDLE) && w_req && !RESET;
    assign w_bad_addr = (Address[1:0] != 2'b00) || (Address[31:ADDR_W+2] != '0);

    // RESP is entered either straight from acceptance (LATENCY=1) or from the last WAIT cycle.
    assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                          ((r_state == ST_WAIT) && (r_count == 4'd1));

    // With LATENCY=1 the access completes on the very edge that accepts it, so the
    // live request fields stand in for the not-yet-latched copies.
    assign w_in_idle   = (r_state == ST_IDLE);
    assign w_cur_store = w_in_idle ? MemWrite                   : r_is_store;
    assign w_cur_bad   = w_in_idle ? w_bad_addr                 : r_bad_addr;
    assign w_cur_word  = w_in_idle ? Address[ADDR_W+1:2]        : r_word;
    assign w_cur_wdata = w_in_idle ? Write_Data                 : r_wdata;

    assign Mem_Stall  = w_accept || (r_state == ST_WAIT);
    assign Resp_Valid = r_resp_valid;
    assign Read_data  = r_read_data;
    assign Addr_Err   = r_addr_err;

    // Control FSM, latched request, error flag and registered response outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_count      <= 4'd0;
            r_is_store   <= 1'b0;
            r_bad_addr   <= 1'b0;
            r_word       <= '0;
            r_wdata      <= 32'd0;
            r_read_data  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_enter_resp;
            if (w_enter_resp && !w_cur_store) begin
                r_read_data <= w_cur_bad ? 32'd0 : r_mem[w_cur_word];
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_store <= MemWrite;
                        r_bad_addr <= w_bad_addr;
                        r_word     <= Address[ADDR_W+1:2];
                        r_wdata    <= Write_Data;
                        r_count    <= 4'(LATENCY - 1);
                        if (w_bad_addr || (MemRead && MemWrite)) begin
                            r_addr_err <= 1'b1;
                        end
                        r_state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - 4'd1;
                    if (r_count == 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage array write on the edge entering RESP; bad addresses never write.
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset; its contents survive RESET and only the
        // control path is cleared, which keeps it mappable onto block RAM.
        if (w_enter_resp && w_cur_store && !w_cur_bad) begin
            r_mem[w_cur_word] <= w_cur_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one LATENCY=3 and one LATENCY=1 instance,
// a transaction-level model checked every cycle, plus directed literal checks.
module tb_dmem_responder;

    localparam int ADDR_W = 10;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] addr_a, wd_a, addr_b, wd_b;
    logic [31:0] rdata_a, rdata_b;
    logic        valid_a, valid_b, stall_a, stall_b, err_a, err_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(3)) dut_a (
        .CLK(CLK), .RESET(RESET), .MemRead(rd_a), .MemWrite(wr_a),
        .Address(addr_a), .Write_Data(wd_a), .Read_data(rdata_a),
        .Resp_Valid(valid_a), .Mem_Stall(stall_a), .Addr_Err(err_a)
    );

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut_b (
        .CLK(CLK), .RESET(RESET), .MemRead(rd_b), .MemWrite(wr_b),
        .Address(addr_b), .Write_Data(wd_b), .Read_data(rdata_b),
        .Resp_Valid(valid_b), .Mem_Stall(stall_b), .Addr_Err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_busy     [2];
    int          m_resp_at  [2];
    int          m_ncyc     [2];
    bit          m_store    [2];
    bit          m_bad      [2];
    int          m_word     [2];
    logic [31:0] m_wd       [2];
    logic [31:0] m_rd       [2];
    bit          m_rd_known [2];
    bit          m_err      [2];
    logic [31:0] m_mem [int];

    function automatic int lat_of(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    task automatic model_step(input int k, input logic rst, input logic q_rd, input logic q_wr,
                              input logic [31:0] q_addr, input logic [31:0] q_wd,
                              input logic o_stall, input logic o_valid,
                              input logic [31:0] o_rdata, input logic o_err);
        string tag = (k == 0) ? "a" : "b";
        bit    e_stall;
        bit    e_valid;
        bit    resp_now;
        int    key;
        m_ncyc[k]++;
        if (rst) begin
            m_busy[k] = 0; m_resp_at[k] = -1;
            m_rd[k] = 32'd0; m_rd_known[k] = 1; m_err[k] = 0;
            check({tag, "_rst_stall"}, {31'd0, o_stall}, 32'd0);
            check({tag, "_rst_valid"}, {31'd0, o_valid}, 32'd0);
            check({tag, "_rst_rdata"}, o_rdata, 32'd0);
            check({tag, "_rst_err"},   {31'd0, o_err},   32'd0);
            return;
        end
        e_valid  = 0;
        resp_now = (m_busy[k] != 0) && (m_ncyc[k] == m_resp_at[k]);
        if (resp_now) begin
            e_valid = 1;
            e_stall = 0;
            key = k * 4096 + m_word[k];
            if (m_store[k]) begin
                if (!m_bad[k]) m_mem[key] = m_wd[k];
            end else if (m_bad[k]) begin
                m_rd[k] = 32'd0; m_rd_known[k] = 1;
            end else if (m_mem.exists(key)) begin
                m_rd[k] = m_mem[key]; m_rd_known[k] = 1;
            end else begin
                m_rd_known[k] = 0;
            end
            m_busy[k] = 0;
        end else if (m_busy[k] != 0) begin
            e_stall = 1;
        end else begin
            e_stall = q_rd | q_wr;
        end
        check({tag, "_stall"}, {31'd0, o_stall}, {31'd0, e_stall});
        check({tag, "_valid"}, {31'd0, o_valid}, {31'd0, e_valid});
        check({tag, "_err"},   {31'd0, o_err},   {31'd0, m_err[k]});
        if (m_rd_known[k]) check({tag, "_rdata"}, o_rdata, m_rd[k]);
        if (!resp_now && (m_busy[k] == 0) && (q_rd || q_wr)) begin
            m_busy[k]    = 1;
            m_resp_at[k] = m_ncyc[k] + lat_of(k);
            m_store[k]   = q_wr;
            m_bad[k]     = (q_addr[1:0] != 2'b00) || ((q_addr >> (ADDR_W + 2)) != 0);
            m_word[k]    = int'(q_addr[ADDR_W+1:2]);
            m_wd[k]      = q_wd;
            if (m_bad[k] || (q_rd && q_wr)) m_err[k] = 1;
        end
    endtask

    always @(negedge CLK) begin
        model_step(0, RESET, rd_a, wr_a, addr_a, wd_a, stall_a, valid_a, rdata_a, err_a);
        model_step(1, RESET, rd_b, wr_b, addr_b, wd_b, stall_b, valid_b, rdata_b, err_b);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int k, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (k == 0) begin
            rd_a = rd; wr_a = wr; addr_a = addr; wd_a = wd;
        end else begin
            rd_b = rd; wr_b = wr; addr_b = addr; wd_b = wd;
        end
    endtask

    function automatic logic stall_of(input int k);
        return (k == 0) ? stall_a : stall_b;
    endfunction

    function automatic logic valid_of(input int k);
        return (k == 0) ? valid_a : valid_b;
    endfunction

    function automatic logic [31:0] rdata_of(input int k);
        return (k == 0) ? rdata_a : rdata_b;
    endfunction

    // One access; returns stall-cycle count, response data, accept and RESP cycles.
    // hold=0 drops the request (and scrambles address/data) right after acceptance.
    task automatic access(input int k, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                          output int stalls, output logic [31:0] rdata,
                          output int acc_cyc, output int resp_cyc);
        bit done = 0;
        @(posedge CLK); #1;
        drive(k, rd, wr, addr, wd);
        stalls = 0; rdata = 32'd0; acc_cyc = -1; resp_cyc = -1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (stall_of(k)) begin
                stalls++;
                if (acc_cyc < 0) acc_cyc = cyc;
            end
            if (valid_of(k)) begin
                rdata = rdata_of(k); resp_cyc = cyc; done = 1;
            end else if (!hold && stalls == 1) begin
                @(posedge CLK); #1;
                drive(k, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
            end
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int k);
        @(posedge CLK); #1;
        drive(k, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st, ac, rc, ac2, rc2;
        logic [31:0] rv;
        RESET = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        check("reset_stall", {31'd0, stall_a}, 32'd0);
        check("reset_valid", {31'd0, valid_a}, 32'd0);
        check("reset_rdata", rdata_a, 32'd0);
        check("reset_err",   {31'd0, err_a},   32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        // Store then load at 0x10, LATENCY=3.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, st, rv, ac, rc);
        check("t1_store_stalls", st, 3);
        check("t1_store_resp_gap", rc - ac, 3);
        access(0, 1'b1, 1'b0, 32'h10, 32'd0, 0, st, rv, ac, rc);
        check("t1_load_stalls", st, 3);
        check("t1_load_data", rv, 32'hDEAD_BEEF);

        // Back-to-back loads with the request held through RESP.
        access(0, 1'b0, 1'b1, 32'h0, 32'h1111_0000, 0, st, rv, ac, rc);
        access(0, 1'b0, 1'b1, 32'h4, 32'h2222_0004, 0, st, rv, ac, rc);
        access(0, 1'b1, 1'b0, 32'h0, 32'd0, 1, st, rv, ac, rc);
        check("t2_load0_data", rv, 32'h1111_0000);
        access(0, 1'b1, 1'b0, 32'h4, 32'd0, 1, st, rv, ac2, rc2);
        check("t2_load4_data", rv, 32'h2222_0004);
        check("t2_resp_spacing", rc2 - rc, 4);
        check("t2_accept_spacing", ac2 - ac, 4);
        idle(0);

        // Misaligned load, then out-of-range store.
        check("t3_err_before", {31'd0, err_a}, 32'd0);
        access(0, 1'b1, 1'b0, 32'h2, 32'd0, 0, st, rv, ac, rc);
        check("t3_bad_load_stalls", st, 3);
        check("t3_bad_load_data", rv, 32'd0);
        check("t3_err_set", {31'd0, err_a}, 32'd1);
        access(0, 1'b0, 1'b1, 32'h1000, 32'hBAD0_BAD0, 0, st, rv, ac, rc);
        check("t3_oor_store_stalls", st, 3);
        check("t3_err_sticky", {31'd0, err_a}, 32'd1);
        access(0, 1'b1, 1'b0, 32'h0, 32'd0, 0, st, rv, ac, rc);
        check("t3_word0_unchanged", rv, 32'h1111_0000);

        // Reset in WAIT abandons the store.
        access(0, 1'b0, 1'b1, 32'h8, 32'hCAFE_0008, 0, st, rv, ac, rc);
        @(posedge CLK); #1;
        drive(0, 1'b0, 1'b1, 32'h8, 32'h0000_1234);
        @(posedge CLK); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t4_wait_stall", {31'd0, stall_a}, 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("t4_rst_stall", {31'd0, stall_a}, 32'd0);
        check("t4_rst_valid", {31'd0, valid_a}, 32'd0);
        check("t4_rst_err",   {31'd0, err_a},   32'd0);
        @(posedge CLK); #1 RESET = 1'b0;
        access(0, 1'b1, 1'b0, 32'h8, 32'd0, 0, st, rv, ac, rc);
        check("t4_old_value", rv, 32'hCAFE_0008);

        // LATENCY=1 instance.
        access(1, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 0, st, rv, ac, rc);
        check("t5_store_stalls", st, 1);
        access(1, 1'b1, 1'b0, 32'h20, 32'd0, 0, st, rv, ac, rc);
        check("t5_load_stalls", st, 1);
        check("t5_load_resp_gap", rc - ac, 1);
        check("t5_load_data", rv, 32'h0BAD_F00D);
        check("t5_err_before", {31'd0, err_b}, 32'd0);
        access(1, 1'b1, 1'b1, 32'h24, 32'h55AA_55AA, 0, st, rv, ac, rc);
        check("t5_both_err", {31'd0, err_b}, 32'd1);
        access(1, 1'b1, 1'b0, 32'h24, 32'd0, 0, st, rv, ac, rc);
        check("t5_both_stored", rv, 32'h55AA_55AA);

        idle(0);
        idle(1);
        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
